// File: rtl/cache_ram_pkg.sv
// Shared widths and transfer-state encoding for the cache <-> RAM line path.
package cache_ram_pkg;

  localparam int RAM_ADDR_SIZE   = 13;
  localparam int RAM_WORD_SIZE   = 16;
  localparam int CACHE_STR_WIDTH = 64;
  localparam int BEATS           = CACHE_STR_WIDTH / RAM_WORD_SIZE;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WR_BEATS  = 3'd1,
    WAIT_WACK = 3'd2,
    RD_ADDR   = 3'd3,
    RD_BEATS  = 3'd4,
    DONE      = 3'd5
  } line_state_e;

endpackage

// File: rtl/ram_wdog.sv
// Clear-on-ack watchdog: counts consecutive ack-low cycles while enabled and
// raises expired once the streak reaches TIMEOUT. The count saturates there.
module ram_wdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic ack_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: any ack or leaving the waiting states restarts the streak.
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || ack_i) begin
      cnt_d = '0;
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Streak counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && (cnt_q == LIMIT);

endmodule

// File: rtl/ram_line_port.sv
// Line-level port toward the 16-bit RAM bus: a cache line writeback becomes a
// burst of write beats, a refill is gathered from read beats. All outputs are
// decoded from registered state, so nothing combinational reaches the buses.
module ram_line_port #(
  parameter int RAM_ADDR_SIZE   = cache_ram_pkg::RAM_ADDR_SIZE,
  parameter int RAM_WORD_SIZE   = cache_ram_pkg::RAM_WORD_SIZE,
  parameter int CACHE_STR_WIDTH = cache_ram_pkg::CACHE_STR_WIDTH,
  parameter int TIMEOUT         = 255
) (
  input  logic                       ram_clk,
  input  logic                       rst,
  input  logic                       line_req,
  input  logic                       line_rnw,
  input  logic [RAM_ADDR_SIZE-1:0]   line_addr,
  input  logic [CACHE_STR_WIDTH-1:0] line_wdata,
  output logic                       line_busy,
  output logic                       line_done,
  output logic                       line_err,
  output logic [CACHE_STR_WIDTH-1:0] line_rdata,
  output logic [RAM_ADDR_SIZE-1:0]   ram_addr,
  output logic                       ram_avalid,
  output logic                       ram_rnw,
  output logic [RAM_WORD_SIZE-1:0]   ram_wdata,
  input  logic [RAM_WORD_SIZE-1:0]   ram_rdata,
  input  logic                       ram_ack
);

  import cache_ram_pkg::*;

  localparam int N_BEATS = CACHE_STR_WIDTH / RAM_WORD_SIZE;
  localparam int CNT_W   = (N_BEATS < 2) ? 1 : $clog2(N_BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_BEATS - 1);

  line_state_e state_q;
  line_state_e state_d;
  logic        err_q;
  logic        err_d;

  logic [RAM_ADDR_SIZE-1:0]   addr_q;
  logic [CACHE_STR_WIDTH-1:0] wdata_q;
  logic [CNT_W-1:0]           cnt_q;
  logic [RAM_WORD_SIZE-1:0]   rbeat_q [N_BEATS];
  logic [RAM_WORD_SIZE-1:0]   wbeat   [N_BEATS];

  logic accept;
  logic capture;
  logic beat_adv;
  logic wdog_en;
  logic wdog_expired;

  assign wdog_en = (state_q == WAIT_WACK) || (state_q == RD_BEATS);

  ram_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk       (ram_clk),
    .rst       (rst),
    .en_i      (wdog_en),
    .ack_i     (ram_ack),
    .expired_o (wdog_expired)
  );

  // Next-state and datapath strobes; a real ack wins over a same-cycle expiry.
  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    accept   = 1'b0;
    capture  = 1'b0;
    beat_adv = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (line_req) begin
          accept  = 1'b1;
          err_d   = 1'b0;
          state_d = line_rnw ? RD_ADDR : WR_BEATS;
        end
      end
      WR_BEATS: begin
        beat_adv = 1'b1;
        if (cnt_q == LAST_BEAT) begin
          state_d = WAIT_WACK;
        end
      end
      WAIT_WACK: begin
        if (ram_ack) begin
          err_d   = 1'b0;
          state_d = DONE;
        end else if (wdog_expired) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      RD_ADDR: begin
        state_d = RD_BEATS;
      end
      RD_BEATS: begin
        if (ram_ack) begin
          capture  = 1'b1;
          beat_adv = 1'b1;
          if (cnt_q == LAST_BEAT) begin
            err_d   = 1'b0;
            state_d = DONE;
          end
        end else if (wdog_expired) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and completion-status registers.
  always_ff @(posedge ram_clk) begin
    if (rst) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  // Request latch, beat counter and refill slots; refill slots clear on accept
  // so a timed-out refill reports zero for every beat it never received.
  always_ff @(posedge ram_clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      for (int k = 0; k < N_BEATS; k++) begin
        rbeat_q[k] <= '0;
      end
    end else if (accept) begin
      addr_q  <= line_addr;
      wdata_q <= line_wdata;
      cnt_q   <= '0;
      for (int k = 0; k < N_BEATS; k++) begin
        rbeat_q[k] <= '0;
      end
    end else begin
      if (capture) begin
        rbeat_q[cnt_q] <= ram_rdata;
      end
      if (beat_adv) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Beat k maps to line bits [k*W +: W], low word first in both directions.
  for (genvar gi = 0; gi < N_BEATS; gi++) begin : g_beat
    assign wbeat[gi] = wdata_q[gi*RAM_WORD_SIZE +: RAM_WORD_SIZE];
    assign line_rdata[gi*RAM_WORD_SIZE +: RAM_WORD_SIZE] = rbeat_q[gi];
  end

  assign line_busy  = (state_q != IDLE) && (state_q != DONE);
  assign line_done  = (state_q == DONE);
  assign line_err   = (state_q == DONE) && err_q;
  assign ram_addr   = addr_q;
  assign ram_avalid = (state_q == WR_BEATS) || (state_q == RD_ADDR);
  assign ram_rnw    = (state_q == RD_ADDR) || (state_q == RD_BEATS);
  assign ram_wdata  = (state_q == WR_BEATS) ? wbeat[cnt_q] : '0;

endmodule
